fsic_wb_decoder: RTL and testbench
==================================

# fsic_wb_decoder

Parametrised Wishbone slave front-end for the FSIC user project. It accepts management-SoC Wishbone cycles and decodes the address into `NUM_TGT` equally sized target windows. Each access is forwarded over a registered request/acknowledge handshake, and the completed access is returned with a single-cycle `wbs_ack`. It extends the single-slave wrapper arrangement with multi-target decode, abort handling, an unmapped-address responder and an optional watchdog timeout with a sticky interrupt.

## Interface
Parameters:
- `NUM_TGT`, 4: number of target windows; power of two, 1..16; `IDXW = max(1, clog2(NUM_TGT))`.
- `TGT_AW`, 12: byte-address bits per window.
- `BASE`, 32'h3000_0000: decode base; bits `[31:TGT_AW+IDXW]` must match.
- `TIMEOUT`, 255: maximum `REQ` cycles before abort; range 1..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned for unmapped or timed-out reads.

Ports:
- `wb_clk` in 1: sole clock.
- `wb_rst` in 1: reset, asynchronous, active-high.
- `wbs_adr` in 32: Wishbone address.
- `wbs_wdata` in 32: Wishbone write data.
- `wbs_sel` in 4: byte enables.
- `wbs_cyc`, `wbs_stb`, `wbs_we` in 1 each: Wishbone cycle, strobe and write-enable.
- `wbs_ack` out 1: single-cycle acknowledge.
- `wbs_rdata` out 32: registered read data.
- `tgt_req` out `NUM_TGT`: one-hot request, held until the target acks.
- `tgt_we` out 1, `tgt_addr` out `TGT_AW`, `tgt_wdata` out 32, `tgt_sel` out 4: captured request fields.
- `tgt_ack` in `NUM_TGT`: per-target acknowledge.
- `tgt_rdata` in `NUM_TGT*32`: per-target read data; target i occupies `[32*i +: 32]`.
- `irq_timeout` out 1: sticky timeout interrupt.
- `err_addr` out 32: address of the first timeout since the last clear.
- `err_clr` in 1: single-cycle clear of `irq_timeout`.

## Operation
- States: `IDLE`, `REQ`, `ACK`. Reset enters `IDLE`.
- Reset values: every output is 0, and `wbs_rdata` is 0.
- Behaviour in `IDLE`, when `wbs_cyc & wbs_stb`:
  - Capture `wbs_adr`, `wbs_wdata`, `wbs_sel` and `wbs_we`.
  - Target index is `wbs_adr[TGT_AW +: IDXW]`.
  - If the upper address bits do not match `BASE`, the access is unmapped: go to `ACK` and drive `wbs_rdata = ERR_DATA` on reads.
  - Otherwise assert `tgt_req[idx]` and go to `REQ`.
- Behaviour in `REQ`:
  - `tgt_req` stays stable. The timeout counter increments each cycle.
  - If `tgt_ack[idx]` is 1: deassert `tgt_req`; on reads capture the `tgt_rdata` slice into `wbs_rdata`; go to `ACK`.
  - Else, if the counter reaches `TIMEOUT`: deassert `tgt_req`; on reads set `wbs_rdata = ERR_DATA`; set `irq_timeout`; load `err_addr` only if `irq_timeout` was 0; go to `ACK`.
  - If `wbs_cyc` drops, the master has aborted: deassert `tgt_req`, go to `IDLE` with no `wbs_ack`, and leave `irq_timeout` unchanged.
- Behaviour in `ACK`: `wbs_ack = 1` for exactly one cycle, then go to `IDLE`.
- Write accesses leave `wbs_rdata` unchanged.
- Boundary conditions:
  - `tgt_ack` from a non-selected target, or any `tgt_ack` outside `REQ`, is ignored.
  - `tgt_ack` in the same cycle the counter reaches `TIMEOUT`: the ack wins and no timeout is recorded.
  - `err_clr` and a timeout in the same cycle: the set wins, and `err_addr` is loaded.
  - Reset asserted mid-transaction clears all state immediately; no ack is issued.

## Timing
- Mapped access: `wbs_stb` is sampled at edge E0 and `tgt_req` is high after E0. If `tgt_ack` is high at edge En, `wbs_ack` is high from En to En+1. Minimum latency is 2 cycles from stb to ack.
- Unmapped access: `wbs_ack` is high for the single cycle after E0.
- Timeout: `wbs_ack` is high `TIMEOUT + 1` cycles after E0.
- Back-to-back: a new strobe is accepted in the `IDLE` cycle that immediately follows `ACK`.
- All outputs are registered.

## Configuration
- `FSIC_WB_TIMEOUT_EN` defined: the watchdog counter, `irq_timeout` and `err_addr` are implemented as described.
- `FSIC_WB_TIMEOUT_EN` undefined: no counter; `REQ` waits indefinitely for an ack or an abort. `irq_timeout` and `err_addr` are tied to 0 and `err_clr` is ignored.

## Test plan
- Mapped read: read 0x3000_1004 with target 1 acking in the first `REQ` cycle and returning 0x1234_5678. Required: `tgt_req = 4'b0010`, `tgt_addr = 0x004`, `wbs_ack` 2 cycles after stb, `wbs_rdata = 0x1234_5678`.
- Unmapped access: read 0x3100_0000. Required: no `tgt_req`, `wbs_ack` 1 cycle after stb, `wbs_rdata = 0xDEAD_BEEF`.
- Timeout (with `TIMEOUT = 8`, macro defined): target 2 never acks on a read of 0x3000_2010. Required: `wbs_ack` at cycle 9, `irq_timeout = 1`, `err_addr = 0x3000_2010`. A second timeout leaves `err_addr` unchanged. Pulsing `err_clr` clears the irq.
- Ack on the timeout boundary: with `TIMEOUT = 8`, the target acks on the eighth `REQ` cycle. Required: `wbs_rdata` takes the target's data and `irq_timeout` stays 0.
- Abort: drop `wbs_cyc` after 3 `REQ` cycles. Required: `tgt_req` is 0 on the next edge and no `wbs_ack`. Then issue a back-to-back write to target 3 with `sel = 4'b0011`; required `tgt_sel = 4'b0011`.
- Reset mid-`REQ`: assert `wb_rst` asynchronously. Required: `tgt_req`, `wbs_ack` and `irq_timeout` are 0 immediately, and the state is `IDLE` after release.

Source files
------------

// File: rtl/fsic_wb_decoder_if.sv
// fsic_wb_decoder_if
//   Wishbone slave bus between the management SoC and fsic_wb_decoder.
//   master modport: the SoC side (drives address/data/strobes, receives ack/rdata).
//   slave modport : the decoder side.
// Signals:
//   wbs_adr[31:0], wbs_wdata[31:0], wbs_sel[3:0], wbs_cyc, wbs_stb, wbs_we  (master -> slave)
//   wbs_ack, wbs_rdata[31:0]                                                  (slave -> master)
interface fsic_wb_decoder_if;
  logic [31:0] wbs_adr;
  logic [31:0] wbs_wdata;
  logic [3:0]  wbs_sel;
  logic        wbs_cyc;
  logic        wbs_stb;
  logic        wbs_we;
  logic        wbs_ack;
  logic [31:0] wbs_rdata;

  modport master (
    output wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    input  wbs_ack, wbs_rdata
  );

  modport slave (
    input  wbs_adr, wbs_wdata, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    output wbs_ack, wbs_rdata
  );
endinterface

// File: rtl/fsic_wb_decoder.sv
// fsic_wb_decoder
//   Wishbone slave front-end that decodes the address into NUM_TGT equal
//   windows and forwards each access over a registered req/ack handshake.
//   Unmapped addresses are answered locally with ERR_DATA. A master abort
//   (wbs_cyc dropped while waiting) returns to IDLE without an ack.
//   Optional feature macro: FSIC_WB_TIMEOUT_EN enables a watchdog that aborts
//   a request after TIMEOUT cycles, answers with ERR_DATA, raises the sticky
//   irq_timeout and records the first offending address in err_addr.
//   Without the macro the request waits indefinitely; irq_timeout/err_addr are 0.
// Ports:
//   wb_clk, wb_rst      clock, asynchronous active-high reset
//   wbs                 Wishbone bus (slave modport), wbs_ack is a 1-cycle pulse
//   tgt_req[NUM_TGT]    one-hot request, held until the selected target acks
//   tgt_we/addr/wdata/sel  captured request fields
//   tgt_ack[NUM_TGT], tgt_rdata[NUM_TGT*32]  per-target ack and read data
//   irq_timeout, err_addr, err_clr  watchdog status and clear
module fsic_wb_decoder #(
  parameter int          NUM_TGT  = 4,
  parameter int          TGT_AW   = 12,
  parameter logic [31:0] BASE     = 32'h3000_0000,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  fsic_wb_decoder_if.slave        wbs,
  output logic [NUM_TGT-1:0]      tgt_req,
  output logic                    tgt_we,
  output logic [TGT_AW-1:0]       tgt_addr,
  output logic [31:0]             tgt_wdata,
  output logic [3:0]              tgt_sel,
  input  logic [NUM_TGT-1:0]      tgt_ack,
  input  logic [NUM_TGT*32-1:0]   tgt_rdata,
  output logic                    irq_timeout,
  output logic [31:0]             err_addr,
  input  logic                    err_clr
);
  localparam int IDXW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int HIW  = TGT_AW + IDXW;

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
  state_t state, state_nx;

  logic [IDXW-1:0]    idx, idx_nx, adr_idx;
  logic [TGT_AW-1:0]  addr_q, addr_nx;
  logic               we_q, we_nx;
  logic [31:0]        wdata_q, wdata_nx;
  logic [3:0]         sel_q, sel_nx;
  logic [NUM_TGT-1:0] req_q, req_nx;
  logic               ack_q, ack_nx;
  logic [31:0]        rdata_q, rdata_nx;
  logic               hit;
  logic               ack_sel;
  logic [31:0]        rdata_sel;

  // An index beyond NUM_TGT (only possible when NUM_TGT == 1) is unmapped.
  assign adr_idx = wbs.wbs_adr[TGT_AW +: IDXW];
  assign hit     = (wbs.wbs_adr[31:HIW] == BASE[31:HIW]) &&
                   ({1'b0, adr_idx} < (IDXW+1)'(NUM_TGT));

  // Only the selected target's ack and data are observed.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (idx == i[IDXW-1:0]) begin
        ack_sel   = tgt_ack[i];
        rdata_sel = tgt_rdata[32*i +: 32];
      end
    end
  end

`ifdef FSIC_WB_TIMEOUT_EN
  logic [15:0] cnt, cnt_nx;
  logic        irq_q, irq_nx;
  logic [31:0] cap_adr, cap_adr_nx;
  logic [31:0] eaddr_q, eaddr_nx;
  logic        tmo_hit;

  // Counter holds completed REQ cycles; the current cycle is the TIMEOUT-th when this fires.
  assign tmo_hit = (cnt + 16'd1) == 16'(TIMEOUT);
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state   <= IDLE;
      idx     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
`ifdef FSIC_WB_TIMEOUT_EN
      cnt     <= '0;
      irq_q   <= 1'b0;
      cap_adr <= '0;
      eaddr_q <= '0;
`endif
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      addr_q  <= addr_nx;
      we_q    <= we_nx;
      wdata_q <= wdata_nx;
      sel_q   <= sel_nx;
      req_q   <= req_nx;
      ack_q   <= ack_nx;
      rdata_q <= rdata_nx;
`ifdef FSIC_WB_TIMEOUT_EN
      cnt     <= cnt_nx;
      irq_q   <= irq_nx;
      cap_adr <= cap_adr_nx;
      eaddr_q <= eaddr_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    addr_nx  = addr_q;
    we_nx    = we_q;
    wdata_nx = wdata_q;
    sel_nx   = sel_q;
    req_nx   = req_q;
    ack_nx   = 1'b0;
    rdata_nx = rdata_q;
`ifdef FSIC_WB_TIMEOUT_EN
    cnt_nx     = cnt;
    cap_adr_nx = cap_adr;
    eaddr_nx   = eaddr_q;
    // A timeout later in this block overrides the clear.
    irq_nx     = err_clr ? 1'b0 : irq_q;
`endif
    case (state)
      IDLE: begin
        if (wbs.wbs_cyc && wbs.wbs_stb) begin
          idx_nx   = adr_idx;
          addr_nx  = wbs.wbs_adr[TGT_AW-1:0];
          we_nx    = wbs.wbs_we;
          wdata_nx = wbs.wbs_wdata;
          sel_nx   = wbs.wbs_sel;
`ifdef FSIC_WB_TIMEOUT_EN
          cnt_nx     = '0;
          cap_adr_nx = wbs.wbs_adr;
`endif
          if (hit) begin
            for (int i = 0; i < NUM_TGT; i++) req_nx[i] = (adr_idx == i[IDXW-1:0]);
            state_nx = REQ;
          end else begin
            ack_nx   = 1'b1;
            state_nx = ACK;
            if (!wbs.wbs_we) rdata_nx = ERR_DATA;
          end
        end
      end
      REQ: begin
        if (!wbs.wbs_cyc) begin
          req_nx   = '0;
          state_nx = IDLE;
        end else if (ack_sel) begin
          req_nx   = '0;
          ack_nx   = 1'b1;
          state_nx = ACK;
          if (!we_q) rdata_nx = rdata_sel;
        end
`ifdef FSIC_WB_TIMEOUT_EN
        else if (tmo_hit) begin
          req_nx   = '0;
          ack_nx   = 1'b1;
          state_nx = ACK;
          if (!we_q) rdata_nx = ERR_DATA;
          // err_addr keeps the first timeout since the last clear.
          if (!irq_q || err_clr) eaddr_nx = cap_adr;
          irq_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
`endif
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        req_nx   = '0;
      end
    endcase
  end

  assign wbs.wbs_ack   = ack_q;
  assign wbs.wbs_rdata = rdata_q;
  assign tgt_req       = req_q;
  assign tgt_we        = we_q;
  assign tgt_addr      = addr_q;
  assign tgt_wdata     = wdata_q;
  assign tgt_sel       = sel_q;
`ifdef FSIC_WB_TIMEOUT_EN
  assign irq_timeout   = irq_q;
  assign err_addr      = eaddr_q;
`else
  assign irq_timeout   = 1'b0;
  assign err_addr      = '0;
`endif
endmodule

// File: tb/tb_fsic_wb_decoder.sv
// tb_fsic_wb_decoder
//   Randomized transaction-level bench for fsic_wb_decoder. Each access is
//   described by its address, direction, the REQ cycle on which the target
//   acks (0 = never), an optional abort cycle and an optional err_clr cycle;
//   the expected ack timing, read data and watchdog status follow from the
//   decode and handshake rules. Timeout cases are built only with
//   FSIC_WB_TIMEOUT_EN defined.
module tb_fsic_wb_decoder;
  localparam int          NUM_TGT = 4;
  localparam int          TGT_AW  = 12;
  localparam int          TMO     = 8;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic wb_clk = 1'b0;
  logic wb_rst;
  always #5 wb_clk = ~wb_clk;

  fsic_wb_decoder_if bus();
  logic [3:0]   tgt_req;
  logic         tgt_we;
  logic [11:0]  tgt_addr;
  logic [31:0]  tgt_wdata;
  logic [3:0]   tgt_sel;
  logic [3:0]   tgt_ack;
  logic [127:0] tgt_rdata;
  logic         irq_timeout;
  logic [31:0]  err_addr;
  logic         err_clr;

  fsic_wb_decoder #(
    .NUM_TGT(NUM_TGT), .TGT_AW(TGT_AW), .BASE(BASE), .TIMEOUT(TMO), .ERR_DATA(ERR)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wbs(bus),
    .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_addr(tgt_addr),
    .tgt_wdata(tgt_wdata), .tgt_sel(tgt_sel), .tgt_ack(tgt_ack),
    .tgt_rdata(tgt_rdata), .irq_timeout(irq_timeout), .err_addr(err_addr),
    .err_clr(err_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state of the observable registers.
  logic [31:0] exp_rdata = '0;
  logic        exp_irq   = 1'b0;
  logic [31:0] exp_eaddr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // d: REQ cycle on which the selected target acks (0 = never)
  // k: REQ cycle on which the master drops cyc (0 = no abort)
  // c: REQ cycle on which err_clr is pulsed (0 = none)
  task automatic run_txn(input logic [31:0] a, input logic we, input logic [3:0] sel,
                         input int d, input int k, input int c);
    logic        mapped;
    int          idx;
    logic [3:0]  oh;
    logic [31:0] wd;
    logic        irq_before;
    bit          done;
    bit          acked;
    idx    = int'(a[13:12]);
    mapped = (a[31:14] == BASE[31:14]);
    oh     = 4'b0001 << idx;
    wd     = $urandom;
    done   = 1'b0;
    acked  = 1'b0;

    @(negedge wb_clk);
    bus.wbs_adr   = a;
    bus.wbs_wdata = wd;
    bus.wbs_sel   = sel;
    bus.wbs_we    = we;
    bus.wbs_cyc   = 1'b1;
    bus.wbs_stb   = 1'b1;
    tgt_ack       = 4'($urandom);
    @(posedge wb_clk); #1;

    if (!mapped) begin
      if (!we) exp_rdata = ERR;
      chk("unmapped_ack",   32'(bus.wbs_ack), 32'd1);
      chk("unmapped_req",   32'(tgt_req), 32'd0);
      chk("unmapped_rdata", bus.wbs_rdata, exp_rdata);
      acked = 1'b1;
    end else begin
      chk("req_onehot", 32'(tgt_req), 32'(oh));
      chk("req_addr",   32'(tgt_addr), 32'(a[11:0]));
      chk("req_sel",    32'(tgt_sel), 32'(sel));
      chk("req_we",     32'(tgt_we), 32'(we));
      chk("req_wdata",  tgt_wdata, wd);
      chk("req_noack",  32'(bus.wbs_ack), 32'd0);
      for (int n = 1; n <= 40 && !done; n++) begin
        @(negedge wb_clk);
        tgt_rdata = {$urandom, $urandom, $urandom, $urandom};
        tgt_ack   = 4'($urandom) & ~oh;
        if (n == d) tgt_ack = tgt_ack | oh;
        err_clr = (n == c);
        if (n == k) begin
          bus.wbs_cyc = 1'b0;
          bus.wbs_stb = 1'b0;
        end
        @(posedge wb_clk); #1;
        irq_before = exp_irq;
`ifdef FSIC_WB_TIMEOUT_EN
        if (n == c) exp_irq = 1'b0;
`endif
        if (n == k) begin
          chk("abort_req", 32'(tgt_req), 32'd0);
          chk("abort_ack", 32'(bus.wbs_ack), 32'd0);
          done = 1'b1;
        end else if (n == d) begin
          if (!we) exp_rdata = tgt_rdata[32*idx +: 32];
          chk("tack_ack",   32'(bus.wbs_ack), 32'd1);
          chk("tack_req",   32'(tgt_req), 32'd0);
          chk("tack_rdata", bus.wbs_rdata, exp_rdata);
          done  = 1'b1;
          acked = 1'b1;
        end
`ifdef FSIC_WB_TIMEOUT_EN
        else if (n == TMO) begin
          if (!we) exp_rdata = ERR;
          if (!irq_before || n == c) exp_eaddr = a;
          exp_irq = 1'b1;
          chk("tmo_ack",   32'(bus.wbs_ack), 32'd1);
          chk("tmo_req",   32'(tgt_req), 32'd0);
          chk("tmo_rdata", bus.wbs_rdata, exp_rdata);
          done  = 1'b1;
          acked = 1'b1;
        end
`endif
        else begin
          chk("wait_ack", 32'(bus.wbs_ack), 32'd0);
          chk("wait_req", 32'(tgt_req), 32'(oh));
        end
        chk("irq",      32'(irq_timeout), 32'(exp_irq));
        chk("err_addr", err_addr, exp_eaddr);
      end
    end

    err_clr = 1'b0;
    if (acked) begin
      @(negedge wb_clk);
      bus.wbs_cyc = 1'b0;
      bus.wbs_stb = 1'b0;
      tgt_ack     = 4'($urandom);
      @(posedge wb_clk); #1;
      chk("ack_single", 32'(bus.wbs_ack), 32'd0);
      chk("ack_req",    32'(tgt_req), 32'd0);
    end
  endtask

  task automatic pulse_clr();
    @(negedge wb_clk);
    err_clr = 1'b1;
    @(posedge wb_clk); #1;
    exp_irq = 1'b0;
    chk("clr_irq",   32'(irq_timeout), 32'd0);
    chk("clr_eaddr", err_addr, exp_eaddr);
    @(negedge wb_clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic        we;
    int          d, k, c, lim;
    bus.wbs_adr = '0; bus.wbs_wdata = '0; bus.wbs_sel = '0;
    bus.wbs_cyc = 1'b0; bus.wbs_stb = 1'b0; bus.wbs_we = 1'b0;
    tgt_ack = '0; tgt_rdata = '0; err_clr = 1'b0;
    wb_rst = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1;
    chk("rst_ack",   32'(bus.wbs_ack), 32'd0);
    chk("rst_rdata", bus.wbs_rdata, 32'd0);
    chk("rst_req",   32'(tgt_req), 32'd0);
    chk("rst_we",    32'(tgt_we), 32'd0);
    chk("rst_addr",  32'(tgt_addr), 32'd0);
    chk("rst_wdata", tgt_wdata, 32'd0);
    chk("rst_sel",   32'(tgt_sel), 32'd0);
    chk("rst_irq",   32'(irq_timeout), 32'd0);
    chk("rst_eaddr", err_addr, 32'd0);
    @(negedge wb_clk);
    wb_rst = 1'b0;

    // Directed cases.
    run_txn(32'h3000_1004, 1'b0, 4'hF, 1, 0, 0);
    run_txn(32'h3100_0000, 1'b0, 4'hF, 0, 0, 0);
    run_txn(32'h3000_2010, 1'b0, 4'hF, TMO, 0, 0);
`ifdef FSIC_WB_TIMEOUT_EN
    run_txn(32'h3000_2010, 1'b0, 4'hF, 0, 0, 0);
    run_txn(32'h3000_3020, 1'b0, 4'hF, 0, 0, 0);
    pulse_clr();
    run_txn(32'h3000_1ABC, 1'b1, 4'h5, 0, 0, TMO);
`endif
    run_txn(32'h3000_0100, 1'b0, 4'hF, 0, 3, 0);
    run_txn(32'h3000_3008, 1'b1, 4'b0011, 2, 0, 0);
    pulse_clr();

    // Asynchronous reset in the middle of a request.
    @(negedge wb_clk);
    bus.wbs_adr = 32'h3000_2000; bus.wbs_we = 1'b0; bus.wbs_sel = 4'hF;
    bus.wbs_cyc = 1'b1; bus.wbs_stb = 1'b1; tgt_ack = '0;
    repeat (3) @(posedge wb_clk);
    #2 wb_rst = 1'b1;
    #1;
    chk("arst_req",   32'(tgt_req), 32'd0);
    chk("arst_ack",   32'(bus.wbs_ack), 32'd0);
    chk("arst_irq",   32'(irq_timeout), 32'd0);
    chk("arst_rdata", bus.wbs_rdata, 32'd0);
    bus.wbs_cyc = 1'b0; bus.wbs_stb = 1'b0;
    exp_rdata = '0; exp_irq = 1'b0; exp_eaddr = '0;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    run_txn(32'h3000_0040, 1'b0, 4'hF, 1, 0, 0);

    // Randomized accesses.
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = BASE | 32'($urandom_range(0, 16383));
      we = 1'($urandom_range(0, 1));
`ifdef FSIC_WB_TIMEOUT_EN
      d = $urandom_range(0, 12);
`else
      d = $urandom_range(1, 12);
`endif
      lim = (d == 0) ? 1000 : d;
`ifdef FSIC_WB_TIMEOUT_EN
      if (lim > TMO) lim = TMO;
`endif
      k = 0;
      if ($urandom_range(0, 5) == 0 && lim > 1) k = $urandom_range(1, lim - 1);
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
      run_txn(a, we, 4'($urandom), d, k, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
